// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA modular-exponentiation sequencer.
package rsa_pkg;

  localparam int unsigned RSA_W       = 6;
  localparam int unsigned RSA_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SQR_REQ,
    ST_SQR_WAIT,
    ST_MUL_REQ,
    ST_MUL_WAIT,
    ST_NEXT,
    ST_DONE
  } rsa_state_e;

endpackage

// File: rtl/rsa_mm_timeout.sv
// Saturating watchdog counter for the multiplier handshake.
// Counting starts in the request cycle, so tc_c fires on the LIMIT-th cycle after mm_start.
module rsa_mm_timeout #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tc_c = en && !clr && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod modulus
// through a shared external modular multiplier (start/done handshake).
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned W       = RSA_W,
  parameter int unsigned TIMEOUT = RSA_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         Done,
  output logic         err,
  output logic [W-1:0] data_out,
  output logic         mm_start,
  output logic [W-1:0] mm_a,
  output logic [W-1:0] mm_b,
  output logic [W-1:0] mm_n,
  input  logic         mm_done,
  input  logic [W-1:0] mm_p
);

  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

  rsa_state_e       state_q,    state_d;
  logic [W-1:0]     base_q,     base_d;
  logic [W-1:0]     exp_q,      exp_d;
  logic [W-1:0]     mod_q,      mod_d;
  logic [W-1:0]     acc_q,      acc_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [W-1:0]     data_q,     data_d;
  logic [W-1:0]     mm_a_q,     mm_a_d;
  logic [W-1:0]     mm_b_q,     mm_b_d;
  logic             err_q,      err_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             mm_start_q, mm_start_d;

  logic tmo_clr_c;
  logic tmo_en_c;
  logic tmo_tc_c;

  rsa_mm_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr_c),
    .en  (tmo_en_c),
    .tc_c(tmo_tc_c)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    data_d     = data_q;
    err_d      = err_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    tmo_en_c   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          mod_d   = modulus;
          acc_d   = W'(1);
          idx_d   = IDX_W'(W - 1);
          err_d   = 1'b0;
          data_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((mod_q < W'(2)) || (base_q >= mod_q)) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SQR_REQ;
        end
      end
      ST_SQR_REQ: begin
        tmo_en_c = 1'b1;
        state_d  = ST_SQR_WAIT;
      end
      ST_SQR_WAIT: begin
        tmo_en_c = !mm_done;
        if (mm_done) begin
          acc_d   = mm_p;
          state_d = exp_q[idx_q] ? ST_MUL_REQ : ST_NEXT;
        end else if (tmo_tc_c) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_MUL_REQ: begin
        tmo_en_c = 1'b1;
        state_d  = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        tmo_en_c = !mm_done;
        if (mm_done) begin
          acc_d   = mm_p;
          state_d = ST_NEXT;
        end else if (tmo_tc_c) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          data_d  = acc_q;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SQR_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Operands are loaded on entry to a request state and held through the wait.
    if (state_d == ST_SQR_REQ) begin
      mm_a_d = acc_d;
      mm_b_d = acc_d;
    end else if (state_d == ST_MUL_REQ) begin
      mm_a_d = acc_d;
      mm_b_d = base_q;
    end

    mm_start_d = (state_d == ST_SQR_REQ) || (state_d == ST_MUL_REQ);
    tmo_clr_c  = mm_start_d;
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      err_q      <= err_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign busy     = busy_q;
  assign Done     = done_q;
  assign err      = err_q;
  assign data_out = data_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_n     = mod_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl with a behavioural modular multiplier.
module tb_rsa_modexp_ctrl;

  localparam int unsigned W       = 6;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LAT     = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp_in;
  logic [W-1:0] modulus;
  logic         busy;
  logic         Done;
  logic         err;
  logic [W-1:0] data_out;
  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_n;
  logic         mm_done;
  logic [W-1:0] mm_p;

  rsa_modexp_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .exp     (exp_in),
    .modulus (modulus),
    .busy    (busy),
    .Done    (Done),
    .err     (err),
    .data_out(data_out),
    .mm_start(mm_start),
    .mm_a    (mm_a),
    .mm_b    (mm_b),
    .mm_n    (mm_n),
    .mm_done (mm_done),
    .mm_p    (mm_p)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_starts = 0;
  int unsigned last_start_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned acc_cyc  = 0;
  logic [W-1:0] cur_n   = '0;

  logic [2*W-1:0] exp_ops[$];
  logic [W:0]     exp_res[$];

  logic           withhold = 1'b0;
  logic           spur     = 1'b0;
  int             pend     = 0;
  logic [W-1:0]   ma, mb, mn;
  logic [2*W-1:0] op;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference square-and-multiply: pushes the expected operand pairs and final result.
  task automatic push_expect(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
    logic [W-1:0] acc;
    if ((n < 2) || (b >= n)) begin
      exp_res.push_back({1'b1, {W{1'b0}}});
      return;
    end
    acc = W'(1);
    for (int i = W - 1; i >= 0; i--) begin
      exp_ops.push_back({acc, acc});
      acc = W'((int'(acc) * int'(acc)) % int'(n));
      if (e[i]) begin
        exp_ops.push_back({acc, b});
        acc = W'((int'(acc) * int'(b)) % int'(n));
      end
    end
    exp_res.push_back({1'b0, acc});
  endtask

  task automatic start_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
    base    = b;
    exp_in  = e;
    modulus = n;
    cur_n   = n;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [W:0] r;
    int k;
    k = 0;
    while ((Done !== 1'b1) && (k < 500)) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    check({tag, "_done"}, 32'(Done), 32'(1));
    r = (exp_res.size() != 0) ? exp_res.pop_front() : '1;
    check({tag, "_err"}, 32'(err), 32'(r[W]));
    check({tag, "_data"}, 32'(data_out), 32'(r[W-1:0]));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ops_left"}, 32'(exp_ops.size()), 32'(0));
  endtask

  // Multiplier model: mm_done LAT cycles after the mm_start cycle.
  always @(negedge clk) begin
    mm_done = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          mm_done = 1'b1;
          mm_p    = (mn == 0) ? '0 : W'((int'(ma) * int'(mb)) % int'(mn));
        end
      end
      if (mm_start) begin
        ma = mm_a;
        mb = mm_b;
        mn = mm_n;
        if (!withhold) pend = LAT;
        if (spur && (mm_a == mm_b)) begin
          spur    = 1'b0;
          mm_done = 1'b1;
          mm_p    = W'(42);
        end
      end
    end
  end

  // Operand scoreboard, checked on every multiplier request.
  always @(negedge clk) begin
    if (!rst && mm_start) begin
      n_starts++;
      last_start_cyc = cyc;
      check("op_pending", 32'(exp_ops.size() != 0), 32'(1));
      if (exp_ops.size() != 0) begin
        op = exp_ops.pop_front();
        check("mm_ab", 32'({mm_a, mm_b}), 32'(op));
      end
      check("mm_n", 32'(mm_n), 32'(cur_n));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; base = '0; exp_in = '0; modulus = '0;
    mm_done = 1'b0; mm_p = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({busy, Done, err, mm_start, data_out, mm_a, mm_b, mm_n}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // 2^7 mod 33
    n_starts = 0;
    push_expect(2, 7, 33);
    start_op(2, 7, 33);
    check("t1_busy", 32'(busy), 32'(1));
    check("t1_done_low", 32'(Done), 32'(0));
    wait_done("t1");
    check("t1_value", 32'(data_out), 32'(29));
    check("t1_nstart", 32'(n_starts), 32'(9));
    repeat (5) @(negedge clk);
    check("t1_hold_done", 32'(Done), 32'(1));
    check("t1_hold_data", 32'(data_out), 32'(29));

    // 3^5 mod 61
    n_starts = 0;
    push_expect(3, 5, 61);
    start_op(3, 5, 61);
    wait_done("t2");
    check("t2_value", 32'(data_out), 32'(60));
    check("t2_nstart", 32'(n_starts), 32'(8));

    // exp = 0
    n_starts = 0;
    push_expect(5, 0, 7);
    start_op(5, 0, 7);
    wait_done("t3a");
    check("t3a_value", 32'(data_out), 32'(1));
    check("t3a_nstart", 32'(n_starts), 32'(6));

    // base >= modulus
    n_starts = 0;
    push_expect(40, 5, 33);
    start_op(40, 5, 33);
    acc_cyc = cyc;
    wait_done("t3b");
    check("t3b_err", 32'(err), 32'(1));
    check("t3b_data", 32'(data_out), 32'(0));
    check("t3b_latency", done_cyc - acc_cyc, 32'(1));
    check("t3b_nstart", 32'(n_starts), 32'(0));

    // Multiplier never answers
    withhold = 1'b1;
    exp_ops.push_back({W'(1), W'(1)});
    exp_res.push_back({1'b1, {W{1'b0}}});
    start_op(2, 7, 33);
    wait_done("t4");
    check("t4_latency", done_cyc - last_start_cyc, 32'(TIMEOUT));
    withhold = 1'b0;
    @(negedge clk);

    // Reset during MUL_WAIT
    push_expect(2, 7, 33);
    start_op(2, 7, 33);
    k = 0;
    while (!(mm_start && (mm_a == W'(1)) && (mm_b == W'(2))) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_mul", 32'(mm_start && (mm_b == W'(2))), 32'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t5_async_clear", 32'({busy, Done, err, mm_start, data_out, mm_a, mm_b, mm_n}), 32'(0));
    @(negedge clk);
    exp_ops.delete();
    exp_res.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_expect(2, 7, 33);
    start_op(2, 7, 33);
    wait_done("t5");
    check("t5_value", 32'(data_out), 32'(29));

    // Stray starts while busy and a spurious mm_done in SQR_REQ
    spur = 1'b1;
    push_expect(2, 7, 33);
    start_op(2, 7, 33);
    for (int i = 0; i < 3; i++) begin
      repeat (7) @(negedge clk);
      base = 5; exp_in = 3; modulus = 61;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("t6");
    check("t6_value", 32'(data_out), 32'(29));

    // Start on the first Done-high cycle
    push_expect(3, 5, 61);
    start_op(3, 5, 61);
    check("t7_done_fell", 32'(Done), 32'(0));
    check("t7_busy", 32'(busy), 32'(1));
    wait_done("t7");
    check("t7_value", 32'(data_out), 32'(60));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
